// File: rtl/mux_n_to_1_pipe_pkg.sv
// Shared constants and helpers for the pipelined datapath word muxes.
//   WIDTH_DEF       : default datapath word width
//   DEFAULT_VAL_DEF : default word driven for an out-of-range select
//   clog2_min1()    : select width for an N-input mux, never below 1 bit
package mux_n_to_1_pipe_pkg;

  localparam int                   WIDTH_DEF       = 32;
  localparam logic [WIDTH_DEF-1:0] DEFAULT_VAL_DEF = '0;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mux_n_to_1_pipe_skid_buf2.sv
// Generic two-entry valid/ready skid buffer.
//   clk, reset            : clock, async active-high reset
//   in_valid/in_ready     : upstream handshake; in_ready comes straight from a flop
//   in_payload            : word captured on accept
//   out_valid/out_ready   : downstream handshake
//   out_payload           : head word, held stable while stalled
// The main entry drives the outputs; the skid entry catches the one word that
// can arrive while main is stalled, which lets in_ready stay registered.
module mux_n_to_1_pipe_skid_buf2 #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_payload,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_payload
);

  logic         main_vld_q, main_vld_d;
  logic         skid_vld_q, skid_vld_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         rdy_q, rdy_d;
  logic         acc, xfer;

  assign acc  = in_valid && rdy_q;
  assign xfer = main_vld_q && out_ready;

  always_comb begin
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    main_d     = main_q;
    skid_d     = skid_q;
    if (xfer || !main_vld_q) begin
      // main frees up: refill from skid first to keep FIFO order
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else if (acc) begin
        main_d     = in_payload;
        main_vld_d = 1'b1;
      end else begin
        main_vld_d = 1'b0;  // main_d keeps the last word
      end
    end else if (acc) begin
      // main stalled: park the new word
      skid_d     = in_payload;
      skid_vld_d = 1'b1;
    end
    rdy_d = !skid_vld_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
      rdy_q      <= 1'b0;  // held low through reset, rises on the first edge after
    end else begin
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      rdy_q      <= rdy_d;
    end
  end

  assign in_ready    = rdy_q;
  assign out_valid   = main_vld_q;
  assign out_payload = main_q;

endmodule

// File: rtl/mux_n_to_1_pipe.sv
// N-input word mux with a registered, valid/ready output stage.
//   clk, reset           : clock, async active-high reset
//   in_data/in_sel       : flattened input words (word i at [i*WIDTH +: WIDTH]) and select
//   in_valid/in_ready    : upstream handshake
//   out_data/out_err     : selected word, flag for an out-of-range select
//   out_valid/out_ready  : downstream handshake
//   err_cnt              : saturating count of accepted out-of-range selects
module mux_n_to_1_pipe
  import mux_n_to_1_pipe_pkg::*;
#(
  parameter int               WIDTH       = WIDTH_DEF,
  parameter int               NUM_IN      = 4,
  parameter int               SEL_W       = clog2_min1(NUM_IN),
  parameter logic [WIDTH-1:0] DEFAULT_VAL = WIDTH'(DEFAULT_VAL_DEF)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              err_cnt
);

  logic [WIDTH-1:0] sel_word;
  logic             sel_err;
  logic [WIDTH:0]   out_payload;
  logic [7:0]       err_cnt_q, err_cnt_d;

  // Explicit equality scan rather than an indexed part-select: a select that
  // matches no input (out of range, or unknown in simulation) falls through
  // to DEFAULT_VAL, so out_data never carries X.
  always_comb begin
    sel_word = DEFAULT_VAL;
    sel_err  = 1'b1;
    for (int i = 0; i < NUM_IN; i++) begin
      if (in_sel == SEL_W'(i)) begin
        sel_word = in_data[i*WIDTH +: WIDTH];
        sel_err  = 1'b0;
      end
    end
  end

  mux_n_to_1_pipe_skid_buf2 #(.W(WIDTH + 1)) u_skid (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_payload  ({sel_err, sel_word}),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_payload (out_payload)
  );

  assign out_err  = out_payload[WIDTH];
  assign out_data = out_payload[WIDTH-1:0];

  // counted at accept time, saturating
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (in_valid && in_ready && sel_err && err_cnt_q != 8'hFF)
      err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_mux_n_to_1_pipe.sv
module tb_mux_n_to_1_pipe;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // spec rule: in-range select passes word sel, otherwise default with err
  function automatic logic [32:0] ref_sel(input logic [511:0] flat, input int n,
                                          input int sel, input logic [31:0] dflt);
    if (sel < n) return {1'b0, flat[sel*32 +: 32]};
    return {1'b1, dflt};
  endfunction

  // DUT A: NUM_IN=4 (power of two), DUT B: NUM_IN=3 with all-ones default
  logic [3:0][31:0] a_w;
  logic [1:0]       a_sel;
  logic             a_iv, a_rdy, a_ov, a_or, a_oe;
  logic [31:0]      a_od;
  logic [7:0]       a_ecnt;
  logic [2:0][31:0] b_w;
  logic [1:0]       b_sel;
  logic             b_iv, b_rdy, b_ov, b_or, b_oe;
  logic [31:0]      b_od;
  logic [7:0]       b_ecnt;

  mux_n_to_1_pipe #(.WIDTH(32), .NUM_IN(4)) dut_a (
    .clk(clk), .reset(reset), .in_data(a_w), .in_sel(a_sel), .in_valid(a_iv),
    .in_ready(a_rdy), .out_data(a_od), .out_err(a_oe), .out_valid(a_ov),
    .out_ready(a_or), .err_cnt(a_ecnt));

  mux_n_to_1_pipe #(.WIDTH(32), .NUM_IN(3), .DEFAULT_VAL(32'hFFFF_FFFF)) dut_b (
    .clk(clk), .reset(reset), .in_data(b_w), .in_sel(b_sel), .in_valid(b_iv),
    .in_ready(b_rdy), .out_data(b_od), .out_err(b_oe), .out_valid(b_ov),
    .out_ready(b_or), .err_cnt(b_ecnt));

  // in_ready captured just after the edge, before out_ready is changed at #2
  logic a_rdy_e, b_rdy_e;
  always @(posedge clk) begin
    #1;
    a_rdy_e = a_rdy;
    b_rdy_e = b_rdy;
  end

  // Scoreboard: at negedge inputs/outputs are stable for the coming edge.
  logic [32:0] aq[$], bq[$];
  int          a_cnt, b_cnt;
  logic        a_hold, b_hold;
  logic [32:0] a_last, b_last;

  always @(negedge clk) begin
    logic [32:0] e;
    if (reset) begin
      aq.delete(); bq.delete();
      a_cnt = 0; b_cnt = 0; a_hold = 0; b_hold = 0;
    end else begin
      chk("A_rdy_no_comb_path", a_rdy, a_rdy_e);
      chk("B_rdy_no_comb_path", b_rdy, b_rdy_e);
      chk("A_err_cnt", a_ecnt, (a_cnt > 255) ? 255 : a_cnt);
      chk("B_err_cnt", b_ecnt, (b_cnt > 255) ? 255 : b_cnt);
      if (a_hold) chk("A_stall_hold", {a_ov, a_oe, a_od}, {1'b1, a_last});
      if (b_hold) chk("B_stall_hold", {b_ov, b_oe, b_od}, {1'b1, b_last});
      if (a_ov && a_or) begin
        chk("A_out_nonempty", aq.size() > 0, 1);
        if (aq.size() > 0) begin e = aq.pop_front(); chk("A_out_word", {a_oe, a_od}, e); end
      end
      if (b_ov && b_or) begin
        chk("B_out_nonempty", bq.size() > 0, 1);
        if (bq.size() > 0) begin e = bq.pop_front(); chk("B_out_word", {b_oe, b_od}, e); end
      end
      a_hold = a_ov && !a_or; a_last = {a_oe, a_od};
      b_hold = b_ov && !b_or; b_last = {b_oe, b_od};
      if (a_iv && a_rdy) begin
        e = ref_sel(512'(a_w), 4, int'(a_sel), 32'h0);
        aq.push_back(e);
        if (e[32]) a_cnt++;
      end
      if (b_iv && b_rdy) begin
        e = ref_sel(512'(b_w), 3, int'(b_sel), 32'hFFFF_FFFF);
        bq.push_back(e);
        if (e[32]) b_cnt++;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  logic [31:0] basic_exp [4];
  int          acc_a, cyc;

  initial begin
    a_w = '0; a_sel = '0; a_iv = 0; a_or = 0;
    b_w = '0; b_sel = '0; b_iv = 0; b_or = 0;
    basic_exp[0] = 32'd1; basic_exp[1] = 32'hDEADBEEF;
    basic_exp[2] = 32'd35; basic_exp[3] = 32'd67;

    // reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst_A_in_ready", a_rdy, 0);
    chk("rst_A_out_valid", a_ov, 0);
    chk("rst_A_out_data", a_od, 0);
    reset = 0;
    tick;
    chk("rel_A_in_ready", a_rdy, 1);

    // out-of-range on NUM_IN=3
    b_or = 1; b_iv = 1; b_sel = 2'd3; b_w = {32'd77, 32'd5, 32'd6};
    tick;
    chk("oor_B_valid", b_ov, 1);
    chk("oor_B_data", b_od, 32'hFFFF_FFFF);
    chk("oor_B_err", b_oe, 1);
    chk("oor_B_cnt", b_ecnt, 1);
    b_sel = 2'd2;
    tick;
    chk("inr_B_data", b_od, 32'd77);
    chk("inr_B_err", b_oe, 0);
    chk("inr_B_cnt", b_ecnt, 1);
    // saturation: 300 more out-of-range accepts
    b_sel = 2'd3;
    repeat (300) tick;
    b_iv = 0;
    tick;
    chk("sat_B_cnt", b_ecnt, 255);

    // backpressure: A=10 held, B=20 parked
    a_or = 0; a_iv = 1; a_sel = 2'd0; a_w[0] = 32'd10;
    tick;
    chk("bp_A_valid", a_ov, 1);
    chk("bp_A_data", a_od, 32'd10);
    chk("bp_A_ready1", a_rdy, 1);
    a_w[0] = 32'd20;
    tick;
    chk("bp_A_hold", a_od, 32'd10);
    chk("bp_A_ready0", a_rdy, 0);
    a_iv = 0; a_or = 1;
    tick;
    chk("bp_B_data", a_od, 32'd20);
    chk("bp_B_valid", a_ov, 1);
    chk("bp_ready_back", a_rdy, 1);
    tick;
    chk("bp_drained", a_ov, 0);

    // reset mid-stream with two words buffered
    a_or = 0; a_iv = 1; a_w[0] = 32'd30;
    tick;
    a_w[0] = 32'd40;
    tick;
    chk("mid_A_full", a_rdy, 0);
    a_iv = 0;
    reset = 1;
    #1;
    chk("mid_rst_valid", a_ov, 0);
    chk("mid_rst_data", a_od, 0);
    chk("mid_rst_B_cnt", b_ecnt, 0);
    chk("mid_rst_ready", a_rdy, 0);
    tick;
    reset = 0;
    #1;
    chk("mid_rel_ready0", a_rdy, 0);
    tick;
    chk("mid_rel_ready1", a_rdy, 1);
    chk("mid_rel_valid", a_ov, 0);

    // basic select, back to back
    a_w = {32'd67, 32'd35, 32'hDEADBEEF, 32'd1};
    a_or = 1; a_iv = 1;
    for (int i = 0; i < 4; i++) begin
      a_sel = 2'(i);
      tick;
      chk("basic_valid", a_ov, 1);
      chk("basic_data", a_od, basic_exp[i]);
    end
    a_iv = 0;
    tick;

    // random soak: 10k words into A, B driven alongside
    acc_a = 0; cyc = 0;
    while (acc_a < 10000 && cyc < 60000) begin
      a_iv = 1'($urandom_range(0, 1)); a_or = 1'($urandom_range(0, 1));
      b_iv = 1'($urandom_range(0, 1)); b_or = 1'($urandom_range(0, 1));
      a_sel = 2'($urandom_range(0, 3)); b_sel = 2'($urandom_range(0, 3));
      for (int i = 0; i < 4; i++) a_w[i] = $urandom;
      for (int i = 0; i < 3; i++) b_w[i] = $urandom;
      if (a_iv && a_rdy) acc_a++;
      tick;
      cyc++;
    end
    chk("soak_budget", acc_a, 10000);
    a_iv = 0; b_iv = 0; a_or = 1; b_or = 1;
    repeat (4) tick;
    chk("soak_A_drained", aq.size(), 0);
    chk("soak_B_drained", bq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mux_n_to_1_pipe.md
Name: mux_n_to_1_pipe

Overview:
- Parametrised N-input, WIDTH-bit word multiplexer with a registered output and a valid/ready handshake on both sides.
- A 2-entry skid buffer sustains one word per cycle while keeping in_ready registered.
- Replaces the single-cycle combinational 2:1 word mux on datapath points that need a pipeline cut: ALU operand select, writeback select, PC source select.
- Out-of-range selects produce a defined value and are flagged.

Parameters:
- WIDTH, 32, data word width in bits.
- NUM_IN, 4, number of input words (2..16).
- SEL_W, $clog2(NUM_IN) (minimum 1), select width.
- DEFAULT_VAL, 0, word emitted when sel >= NUM_IN.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  NUM_IN*WIDTH  flattened inputs; word i is bits [i*WIDTH +: WIDTH].
- in_sel  input  SEL_W  index of the word to pass.
- in_valid  input  1  in_data/in_sel are valid this cycle.
- in_ready  output  1  block can accept this cycle.
- out_data  output  WIDTH  selected word.
- out_err  output  1  the word on out_data came from an out-of-range select.
- out_valid  output  1  out_data/out_err are valid.
- out_ready  input  1  downstream accepts this cycle.
- err_cnt  output  8  saturating count of accepted out-of-range selects.

Behaviour:
- Interface (already decided): one clock, clk; reset is asynchronous and active-high, reset.
- Reset, asserted at any time including mid-transfer:
  - main and skid entries invalidated; out_valid=0, out_data=0, out_err=0, err_cnt=0.
  - in_ready=0 while reset is high; in_ready=1 in the first cycle after deassertion.
  - In-flight words are dropped.
- Accept: accept occurs when in_valid && in_ready at a rising edge.
  - Selected word = in_data[in_sel*WIDTH +: WIDTH] if in_sel < NUM_IN, else DEFAULT_VAL with err=1.
  - Selection is purely combinational from the same-cycle inputs; nothing is sampled earlier.
- Latency: exactly 1 cycle. A word accepted at edge k appears with out_valid=1 from edge k onward, i.e. visible in cycle k+1.
- Output transfer: occurs when out_valid && out_ready. out_data/out_err hold stable while out_valid && !out_ready.
- Skid buffer, two entries: main (drives outputs) and skid.
  - in_ready = !skid_valid, taken from a register; no combinational path from out_ready to in_ready.
  - Accept while main is empty or main is transferring, with skid empty: word goes to main.
  - Accept while main is stalled (out_valid && !out_ready): word goes to skid; in_ready drops next cycle.
  - Main transfers while skid is valid: main <= skid, skid cleared, in_ready=1 next cycle. The simultaneous accept cannot happen because in_ready=0.
  - Main transfers with no new accept and skid empty: out_valid=0 next cycle; out_data keeps its last value (don't-care for the checker).
- Throughput: 1 word/cycle with out_ready held high. Order is strictly FIFO; no word is lost or duplicated.
- err_cnt:
  - Increments by 1 on each accept with in_sel >= NUM_IN.
  - Saturates at 255.
  - Cleared only by reset.
  - Counts at accept, not at output.
- When NUM_IN is a power of two, the out-of-range path is unreachable: out_err stays 0 and err_cnt stays 0.
- No X propagation: an unknown or out-of-range sel never produces X on out_data.

Decomposition:
- Shared package: WIDTH default constant (32), DEFAULT_VAL constant, and a clog2 helper function used for SEL_W across datapath muxes.
- One sub-module is natural: skid_buf2, a generic 2-entry valid/ready skid buffer with payload width WIDTH+1 (data plus err).
  - Its handshake rules are exactly those in Behaviour.
  - It is reusable for other pipeline cuts in the datapath.
- The select logic and err_cnt stay in mux_n_to_1_pipe.

Test Plan:
- Reset: assert reset mid-stream with two words buffered → out_valid=0, out_data=0, err_cnt=0 immediately (async); in_ready=1 one cycle after release.
- Basic select: NUM_IN=4, in_data={w3=67, w2=35, w1=0xDEADBEEF, w0=1}, in_sel stepping 0,1,2,3 each cycle, out_ready=1 → out_data 1, 0xDEADBEEF, 35, 67 on consecutive cycles starting one cycle after the first accept; no bubbles.
- Backpressure: out_ready=0 while sending words A=10 then B=20 → A held on out_data, B parked in skid, in_ready=0 from the cycle after B. Raising out_ready → A, then B, then in_ready=1.
- Out-of-range: NUM_IN=3, DEFAULT_VAL=32'hFFFF_FFFF, in_sel=3 → out_data=FFFFFFFF, out_err=1, err_cnt=1. Next in_sel=2 → out_err=0.
- Saturation: 300 accepts with in_sel=3 (NUM_IN=3) → err_cnt stops at 255.
- Random soak: random in_valid/out_ready at 50% each, 10k words, scoreboard → output sequence equals reference-model selection in order. in_ready never depends combinationally on out_ready (checked by assertion).
